pulse_stretch: RTL and testbench

Converts single-cycle event strobes on the 5 kHz button clock into human-visible level pulses. It is the output-side counterpart to the button edge detector: strobes such as step-taken, trap or write-commit become one fixed-width LED pulse each, separated by a guaranteed dark gap. Events that arrive while a pulse is showing are counted and replayed in order, so none is lost below the queue limit.

---
 rtl/pulse_stretch_pkg.sv | 34 +++
 rtl/sat_counter.sv | 38 +++
 rtl/pulse_stretch.sv | 125 ++++++++++++
 tb/tb_pulse_stretch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding, default
// timing parameters and width helpers used to size the timer and queue.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_HIGH_CYCLES = 2500;
    localparam int DEF_GAP_CYCLES  = 1250;
    localparam int DEF_PEND_MAX    = 7;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Bits needed to hold values 0..count-1, never less than one.
    function automatic int bits_for(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at MAX. An increment that would pass MAX
// is discarded and sets the sticky sat flag; simultaneous inc and dec leave
// the count unchanged and never set sat.
module sat_counter
#(
    parameter int PW  = 3,
    parameter int MAX = 7
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] count,
    output logic          sat
);

    localparam logic [PW-1:0] COUNT_MAX = PW'(MAX);

    // Count update with saturation; sat is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == COUNT_MAX) begin
                sat <= 1'b1;
            end else begin
                count <= count + PW'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - PW'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into fixed-width level pulses with a
// guaranteed dark gap after each one. Events arriving while a pulse or gap
// is showing are queued in a saturating counter and replayed in turn.
// Optional feature macro: PULSE_STRETCH_RETRIG_EN -- an event during the
// high phase extends the current pulse instead of being queued.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter  int HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter  int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter  int PEND_MAX    = DEF_PEND_MAX,
    localparam int PW          = clog2(PEND_MAX + 1)
)
(
    input  logic          clk5K,
    input  logic          rst_n,
    input  logic          pulse_in,
    output logic          level_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int CW = bits_for(max_int(HIGH_CYCLES, GAP_CYCLES));
    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt;
    logic          queue_inc;
    logic          queue_dec;

    // State, timer and output level registers.
    always_ff @(posedge clk5K or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            level_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
        end
    end

    // Next-state, timer reload and queue push/pop decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_out;
        queue_inc = 1'b0;
        queue_dec = 1'b0;
        case (state)
            ST_IDLE: begin
                // An event in IDLE is shown directly, never queued.
                if (pulse_in) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = HIGH_LOAD;
                    level_nxt = 1'b1;
                end
            end
            ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIG_EN
                if (pulse_in) begin
                    cnt_nxt = HIGH_LOAD;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                    level_nxt = 1'b0;
                end
`else
                queue_inc = pulse_in;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                    level_nxt = 1'b0;
                end
`endif
            end
            ST_GAP: begin
                // At the exit edge an arriving event and a consume cancel
                // out in the counter, so pending holds and cannot overflow.
                queue_inc = pulse_in;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if ((pending != '0) || pulse_in) begin
                    queue_dec = 1'b1;
                    state_nxt = ST_HIGH;
                    cnt_nxt   = HIGH_LOAD;
                    level_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    // Busy reflects the state register only.
    always_comb begin
        busy = (state != ST_IDLE);
    end

    sat_counter #(
        .PW  (PW),
        .MAX (PEND_MAX)
    ) u_queue (
        .clk   (clk5K),
        .rst_n (rst_n),
        .inc   (queue_inc),
        .dec   (queue_dec),
        .count (pending),
        .sat   (overflow)
    );

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with HIGH_CYCLES=4, GAP_CYCLES=2,
// PEND_MAX=3. Edge 0 is the first rising edge after reset release; outputs
// are sampled 1 time unit after each rising edge.
module tb_pulse_stretch;

    logic       clk;
    logic       rst_n;
    logic       pulse_in;
    logic       level_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int vectors;
    int miscompares;

    pulse_stretch #(
        .HIGH_CYCLES (4),
        .GAP_CYCLES  (2),
        .PEND_MAX    (3)
    ) dut (
        .clk5K     (clk),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int e, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input int e);
        check({tag, "_level"}, e, {3'b0, level_out}, 4'd0);
        check({tag, "_busy"},  e, {3'b0, busy},      4'd0);
        check({tag, "_pend"},  e, {2'b0, pending},   4'd0);
        check({tag, "_ovf"},   e, {3'b0, overflow},  4'd0);
    endtask

    // Hold reset with pulse_in toggling, check outputs stay zero, release
    // on a falling edge so the next rising edge is edge 0.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_in = i[0];
            @(negedge clk);
            check_all_zero(tag, i);
        end
        pulse_in = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Drive pulse_in for edge e, then check the outputs after that edge.
    task automatic run_edge(input string tag, input int e, input logic pin,
                            input logic el, input logic eb, input logic [1:0] ep, input logic eo);
        pulse_in = pin;
        @(posedge clk);
        #1;
        pulse_in = 1'b0;
        check({tag, "_level"}, e, {3'b0, level_out}, {3'b0, el});
        check({tag, "_busy"},  e, {3'b0, busy},      {3'b0, eb});
        check({tag, "_pend"},  e, {2'b0, pending},   {2'b0, ep});
        check({tag, "_ovf"},   e, {3'b0, overflow},  {3'b0, eo});
    endtask

    initial begin
        logic       el;
        logic       eb;
        logic [1:0] ep;
        logic       eo;
        vectors     = 0;
        miscompares = 0;
        pulse_in    = 1'b0;
        rst_n       = 1'b1;
        #3;

        // Reset with pulse_in toggling.
        do_reset("rst_hold");

        // Single event at edge 0: high after edges 0-3, busy until edge 6.
        for (int e = 0; e < 8; e++) begin
            el = (e <= 3);
            eb = (e <= 5);
            run_edge("single", e, (e == 0), el, eb, 2'd0, 1'b0);
        end

`ifndef PULSE_STRETCH_RETRIG_EN
        // Events at edges 0,1,2: windows start at 0, 6, 12; idle after 18.
        do_reset("rst_b2b");
        for (int e = 0; e < 20; e++) begin
            el = (e <= 3) || (e >= 6 && e <= 9) || (e >= 12 && e <= 15);
            eb = (e <= 17);
            if (e == 0)      ep = 2'd0;
            else if (e == 1) ep = 2'd1;
            else if (e <= 5) ep = 2'd2;
            else if (e <= 11) ep = 2'd1;
            else             ep = 2'd0;
            run_edge("three", e, (e <= 2), el, eb, ep, 1'b0);
        end

        // Events at edges 0-4: queue saturates at 3, fifth event dropped.
        do_reset("rst_ovf");
        for (int e = 0; e < 26; e++) begin
            el = (e <= 3) || (e >= 6 && e <= 9) || (e >= 12 && e <= 15) || (e >= 18 && e <= 21);
            eb = (e <= 23);
            if (e == 0)       ep = 2'd0;
            else if (e == 1)  ep = 2'd1;
            else if (e == 2)  ep = 2'd2;
            else if (e <= 5)  ep = 2'd3;
            else if (e <= 11) ep = 2'd2;
            else if (e <= 17) ep = 2'd1;
            else              ep = 2'd0;
            eo = (e >= 4);
            run_edge("five", e, (e <= 4), el, eb, ep, eo);
        end
`endif

        // Events at edges 0 and 1, then reset asserted before edge 2.
        do_reset("rst_mid");
`ifdef PULSE_STRETCH_RETRIG_EN
        run_edge("mid", 0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
        run_edge("mid", 1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
`else
        run_edge("mid", 0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
        run_edge("mid", 1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_async", 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            run_edge("post_rst", e, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        end

`ifdef PULSE_STRETCH_RETRIG_EN
        // Events at edges 0 and 2 merge into one 6-cycle pulse.
        do_reset("rst_retrig");
        for (int e = 0; e < 10; e++) begin
            el = (e <= 5);
            eb = (e <= 7);
            run_edge("retrig", e, (e == 0 || e == 2), el, eb, 2'd0, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
